// File: rtl/smc_pkg.sv
// ----------------------------------------------------------------------------
// smc_pkg
// Shared constants for the SMC register router:
//   - register addresses of the keyboard / mouse back-end registers
//   - read value returned for unmapped registers
//   - 2-bit router FSM state encoding
//   - debug snapshot struct of the router FSM
// Optional feature macro used by the importers: SMC_MOUSE_EN.
// ----------------------------------------------------------------------------
package smc_pkg;

    localparam logic [7:0] REG_KBD_BUF  = 8'h07;
    localparam logic [7:0] REG_KBD_STAT = 8'h18;
    localparam logic [7:0] REG_KBD_CMD  = 8'h19;
    localparam logic [7:0] REG_MS_BUF   = 8'h21;
    localparam logic [7:0] NODEV_BYTE   = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    typedef struct packed {
        logic [1:0] state;
        logic       devsel_q;
    } smc_dbg_t;

endpackage

// File: rtl/smc_tx_mux.sv
// ----------------------------------------------------------------------------
// smc_tx_mux
// Combinational read-data selection and pop-target decode from the latched
// register address and the source FIFO heads.
// Ports:
//   i_reg          latched register address
//   i_kbd_code     keyboard FIFO head,   i_kbd_code_v keyboard FIFO non-empty
//   i_kbd_stat     keyboard status byte
//   i_ms_byte      mouse FIFO head,      i_ms_byte_v  mouse FIFO non-empty
//   o_txbyte       byte to transmit
//   o_kbd_pop_ok   a consumed byte must pop the keyboard FIFO
//   o_ms_pop_ok    a consumed byte must pop the mouse FIFO
// Macro SMC_MOUSE_EN: when undefined the mouse register reads as NODEV_BYTE
// and never requests a pop.
// ----------------------------------------------------------------------------
module smc_tx_mux
    import smc_pkg::*;
(
    input  logic [7:0] i_reg,
    input  logic [7:0] i_kbd_code,
    input  logic       i_kbd_code_v,
    input  logic [7:0] i_kbd_stat,
    input  logic [7:0] i_ms_byte,
    input  logic       i_ms_byte_v,
    output logic [7:0] o_txbyte,
    output logic       o_kbd_pop_ok,
    output logic       o_ms_pop_ok
);

`ifndef SMC_MOUSE_EN
    // Mouse source is not routed in this build.
    logic w_unused_ms;
    assign w_unused_ms = ^{i_ms_byte, i_ms_byte_v};
`endif

    always_comb begin
        o_txbyte     = NODEV_BYTE;
        o_kbd_pop_ok = 1'b0;
        o_ms_pop_ok  = 1'b0;
        case (i_reg)
            REG_KBD_BUF: begin
                // An empty FIFO sends 0x00 and must not be popped.
                o_txbyte     = i_kbd_code_v ? i_kbd_code : 8'h00;
                o_kbd_pop_ok = i_kbd_code_v;
            end
            REG_KBD_STAT: begin
                o_txbyte = i_kbd_stat;
            end
`ifdef SMC_MOUSE_EN
            REG_MS_BUF: begin
                o_txbyte    = i_ms_byte_v ? i_ms_byte : 8'h00;
                o_ms_pop_ok = i_ms_byte_v;
            end
`endif
            default: begin
                o_txbyte = NODEV_BYTE;
            end
        endcase
    end

endmodule

// File: rtl/smc_reg_router.sv
// ----------------------------------------------------------------------------
// smc_reg_router
// Register-level controller between the SMC I2C slave and the PS/2 keyboard
// and mouse hosts. The first byte of an I2C write selects the register; the
// following write bytes go to the keyboard command register when addressed.
// Reads return the addressed source and pop it once per consumed byte.
// Ports:
//   clk6x, resetn               clock, asynchronous active-low reset
//   devsel_i, rw_bit_i          I2C slave selected, 1=read / 0=write
//   rxbyte_i, rxbyte_v_i        received byte and its 1T valid
//   txbyte_o, txbyte_deq_i      byte to send (combinational), 1T consumed
//   kbd_code_i/_v_i/_rd_o       keyboard FWFT FIFO head, non-empty, 1T pop
//   kbd_stat_i                  keyboard status byte
//   kbd_cmd_o/_v_o, kbd_cmd_busy_i  keyboard command byte, 1T valid, busy
//   ms_byte_i/_v_i/_rd_o        mouse FWFT FIFO head, non-empty, 1T pop
//   reg_o                       latched register address
//   cmd_drop_o                  sticky: a keyboard command was dropped
// Handshake: every *_v/_deq/_rd strobe is a single-cycle pulse; a pop or
// command pulse is registered, so it appears the cycle after its cause, and a
// source must present its new head/valid within one cycle of being popped.
// Macro SMC_MOUSE_EN enables the mouse buffer register; otherwise it reads
// as 0xFF and ms_byte_rd_o is tied low.
// ----------------------------------------------------------------------------
module smc_reg_router
    import smc_pkg::*;
(
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       devsel_i,
    input  logic       rw_bit_i,
    input  logic [7:0] rxbyte_i,
    input  logic       rxbyte_v_i,
    output logic [7:0] txbyte_o,
    input  logic       txbyte_deq_i,
    input  logic [7:0] kbd_code_i,
    input  logic       kbd_code_v_i,
    output logic       kbd_code_rd_o,
    input  logic [7:0] kbd_stat_i,
    output logic [7:0] kbd_cmd_o,
    output logic       kbd_cmd_v_o,
    input  logic       kbd_cmd_busy_i,
    input  logic [7:0] ms_byte_i,
    input  logic       ms_byte_v_i,
    output logic       ms_byte_rd_o,
    output logic [7:0] reg_o,
    output logic       cmd_drop_o
);

    logic       r_devsel_q;
    logic [1:0] r_state;
    logic [7:0] r_reg;
    logic       r_cmd_drop;
    logic       r_kbd_rd;
    logic [7:0] r_kbd_cmd;
    logic       r_kbd_cmd_v;

    logic       w_rise;
    logic       w_deq_fire;
    logic       w_kbd_pop_ok;
    logic       w_ms_pop_ok;
    smc_dbg_t   w_dbg;

    assign w_rise = devsel_i & ~r_devsel_q;

    // A deq counts only while a read is in progress and not superseded by a
    // new start or a deselect in the same cycle.
    assign w_deq_fire = devsel_i & ~w_rise & (r_state == ST_RDATA) & txbyte_deq_i;

    // FSM snapshot for checkers.
    assign w_dbg.state    = r_state;
    assign w_dbg.devsel_q = r_devsel_q;

    smc_tx_mux u_tx_mux (
        .i_reg        (r_reg),
        .i_kbd_code   (kbd_code_i),
        .i_kbd_code_v (kbd_code_v_i),
        .i_kbd_stat   (kbd_stat_i),
        .i_ms_byte    (ms_byte_i),
        .i_ms_byte_v  (ms_byte_v_i),
        .o_txbyte     (txbyte_o),
        .o_kbd_pop_ok (w_kbd_pop_ok),
        .o_ms_pop_ok  (w_ms_pop_ok)
    );

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            r_devsel_q  <= 1'b0;
            r_state     <= ST_IDLE;
            r_reg       <= 8'h00;
            r_cmd_drop  <= 1'b0;
            r_kbd_rd    <= 1'b0;
            r_kbd_cmd   <= 8'h00;
            r_kbd_cmd_v <= 1'b0;
        end else begin
            r_devsel_q  <= devsel_i;
            r_kbd_rd    <= w_deq_fire & w_kbd_pop_ok;
            r_kbd_cmd_v <= 1'b0;

            if (!devsel_i) begin
                r_state <= ST_IDLE;
            end else if (w_rise) begin
                // Fresh start, or repeated start from any state.
                r_state <= rw_bit_i ? ST_RDATA : ST_ADDR;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (rxbyte_v_i) begin
                            r_reg      <= rxbyte_i;
                            r_cmd_drop <= 1'b0;
                            r_state    <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (rxbyte_v_i && (r_reg == REG_KBD_CMD)) begin
                            if (kbd_cmd_busy_i) begin
                                r_cmd_drop <= 1'b1;
                            end else begin
                                r_kbd_cmd   <= rxbyte_i;
                                r_kbd_cmd_v <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE ignores byte strobes; RDATA pops are handled
                        // through w_deq_fire.
                    end
                endcase
            end
        end
    end

`ifdef SMC_MOUSE_EN
    logic r_ms_rd;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            r_ms_rd <= 1'b0;
        end else begin
            r_ms_rd <= w_deq_fire & w_ms_pop_ok;
        end
    end

    assign ms_byte_rd_o = r_ms_rd;
`else
    logic w_unused_ms_pop;
    assign w_unused_ms_pop = w_ms_pop_ok;
    assign ms_byte_rd_o    = 1'b0;
`endif

    assign kbd_code_rd_o = r_kbd_rd;
    assign kbd_cmd_o     = r_kbd_cmd;
    assign kbd_cmd_v_o   = r_kbd_cmd_v;
    assign reg_o         = r_reg;
    assign cmd_drop_o    = r_cmd_drop;

endmodule

// File: tb/tb_smc_reg_router.sv
module tb_smc_reg_router;

  logic       clk6x;
  logic       resetn;
  logic       devsel_i;
  logic       rw_bit_i;
  logic [7:0] rxbyte_i;
  logic       rxbyte_v_i;
  logic [7:0] txbyte_o;
  logic       txbyte_deq_i;
  logic [7:0] kbd_code_i;
  logic       kbd_code_v_i;
  logic       kbd_code_rd_o;
  logic [7:0] kbd_stat_i;
  logic [7:0] kbd_cmd_o;
  logic       kbd_cmd_v_o;
  logic       kbd_cmd_busy_i;
  logic [7:0] ms_byte_i;
  logic       ms_byte_v_i;
  logic       ms_byte_rd_o;
  logic [7:0] reg_o;
  logic       cmd_drop_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  // FWFT FIFO models: the bench writes entries, the pop strobes advance rd.
  logic [7:0] kbd_mem [16];
  logic [3:0] kbd_wr = 4'd0;
  logic [3:0] kbd_rd_ptr = 4'd0;
  logic [7:0] ms_mem [16];
  logic [3:0] ms_wr = 4'd0;
  logic [3:0] ms_rd_ptr = 4'd0;

  int kbd_pops = 0;
  int ms_pops  = 0;
  int cmd_pulses = 0;

  assign kbd_code_v_i = (kbd_rd_ptr != kbd_wr);
  assign kbd_code_i   = kbd_mem[kbd_rd_ptr];
  assign ms_byte_v_i  = (ms_rd_ptr != ms_wr);
  assign ms_byte_i    = ms_mem[ms_rd_ptr];

  smc_reg_router dut (
    .clk6x          (clk6x),
    .resetn         (resetn),
    .devsel_i       (devsel_i),
    .rw_bit_i       (rw_bit_i),
    .rxbyte_i       (rxbyte_i),
    .rxbyte_v_i     (rxbyte_v_i),
    .txbyte_o       (txbyte_o),
    .txbyte_deq_i   (txbyte_deq_i),
    .kbd_code_i     (kbd_code_i),
    .kbd_code_v_i   (kbd_code_v_i),
    .kbd_code_rd_o  (kbd_code_rd_o),
    .kbd_stat_i     (kbd_stat_i),
    .kbd_cmd_o      (kbd_cmd_o),
    .kbd_cmd_v_o    (kbd_cmd_v_o),
    .kbd_cmd_busy_i (kbd_cmd_busy_i),
    .ms_byte_i      (ms_byte_i),
    .ms_byte_v_i    (ms_byte_v_i),
    .ms_byte_rd_o   (ms_byte_rd_o),
    .reg_o          (reg_o),
    .cmd_drop_o     (cmd_drop_o)
  );

  // ---------------- clock / reset ----------------
  initial clk6x = 1'b0;
  always #10 clk6x = ~clk6x;

  always @(posedge clk6x) begin
    if (kbd_code_rd_o) begin
      kbd_pops <= kbd_pops + 1;
      if (kbd_code_v_i) kbd_rd_ptr <= kbd_rd_ptr + 4'd1;
    end
    if (ms_byte_rd_o) begin
      ms_pops <= ms_pops + 1;
      if (ms_byte_v_i) ms_rd_ptr <= ms_rd_ptr + 4'd1;
    end
    if (kbd_cmd_v_o) cmd_pulses <= cmd_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk6x);
    #1;
  endtask

  task automatic kbd_push(input logic [7:0] b);
    kbd_mem[kbd_wr] = b;
    kbd_wr = kbd_wr + 4'd1;
  endtask

  task automatic ms_push(input logic [7:0] b);
    ms_mem[ms_wr] = b;
    ms_wr = ms_wr + 4'd1;
  endtask

  task automatic start(input logic rw);
    devsel_i = 1'b1;
    rw_bit_i = rw;
    step();
  endtask

  task automatic stop();
    devsel_i = 1'b0;
    step();
    step();
  endtask

  task automatic send(input logic [7:0] b);
    rxbyte_i   = b;
    rxbyte_v_i = 1'b1;
    step();
    rxbyte_v_i = 1'b0;
  endtask

  // Consume the bytes already queued in exp_q from the current read;
  // the pop strobe selected by kind (0 none, 1 kbd, 2 mouse) must pulse
  // once per non-empty byte, exactly one cycle after its deq.
  task automatic read_bytes(input int n, input int kind, input string tag);
    logic [7:0] e;
    logic       want;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_tx"}, {24'd0, txbyte_o}, {24'd0, e});
      want = (kind != 0) && ((kind == 1) ? kbd_code_v_i : ms_byte_v_i);
      txbyte_deq_i = 1'b1;
      step();
      txbyte_deq_i = 1'b0;
      check({tag, "_kbd_rd"}, {31'd0, kbd_code_rd_o}, {31'd0, want && (kind == 1)});
      check({tag, "_ms_rd"},  {31'd0, ms_byte_rd_o},  {31'd0, want && (kind == 2)});
      step();
      check({tag, "_rd_end"}, {30'd0, kbd_code_rd_o, ms_byte_rd_o}, 32'd0);
    end
  endtask

  task automatic write_addr(input logic [7:0] a);
    start(1'b0);
    send(a);
  endtask

  // ---------------- main sequence ----------------
  int p0;
  initial begin
    resetn = 1'b0;
    devsel_i = 1'b0; rw_bit_i = 1'b0; rxbyte_i = 8'h00; rxbyte_v_i = 1'b0;
    txbyte_deq_i = 1'b0; kbd_stat_i = 8'h00; kbd_cmd_busy_i = 1'b0;
    for (int i = 0; i < 16; i++) begin kbd_mem[i] = 8'h00; ms_mem[i] = 8'h00; end
    step(); step();
    check("rst_reg",  {24'd0, reg_o}, 32'h00);
    check("rst_drop", {31'd0, cmd_drop_o}, 32'd0);
    check("rst_pulses", {29'd0, kbd_code_rd_o, ms_byte_rd_o, kbd_cmd_v_o}, 32'd0);
    check("rst_cmd",  {24'd0, kbd_cmd_o}, 32'h00);
    resetn = 1'b1;
    step();

    // Keyboard buffer: two codes queued, third read sees an empty FIFO.
    kbd_push(8'h1C); kbd_push(8'hF0);
    write_addr(8'h07);
    check("addr07", {24'd0, reg_o}, 32'h07);
    stop();
    start(1'b1);
    p0 = kbd_pops;
    exp_q.push_back(8'h1C); exp_q.push_back(8'hF0); exp_q.push_back(8'h00);
    read_bytes(3, 1, "kbdbuf");
    check("kbdbuf_pops", p0 + 2, kbd_pops);
    stop();

    // Command write, not busy.
    p0 = cmd_pulses;
    write_addr(8'h19);
    send(8'hFF);
    check("cmd_v", {31'd0, kbd_cmd_v_o}, 32'd1);
    check("cmd_o", {24'd0, kbd_cmd_o}, 32'hFF);
    step();
    check("cmd_v_end", {31'd0, kbd_cmd_v_o}, 32'd0);
    check("cmd_pulses1", cmd_pulses, p0 + 1);
    check("cmd_nodrop", {31'd0, cmd_drop_o}, 32'd0);
    stop();

    // Command write: second byte arrives while busy and is dropped.
    p0 = cmd_pulses;
    write_addr(8'h19);
    send(8'hED);
    kbd_cmd_busy_i = 1'b1;
    send(8'h02);
    kbd_cmd_busy_i = 1'b0;
    step();
    check("drop_cmd_o", {24'd0, kbd_cmd_o}, 32'hED);
    check("drop_pulses", cmd_pulses, p0 + 1);
    check("drop_set", {31'd0, cmd_drop_o}, 32'd1);
    stop();
    check("drop_sticky", {31'd0, cmd_drop_o}, 32'd1);
    write_addr(8'h18);
    check("drop_clr", {31'd0, cmd_drop_o}, 32'd0);
    stop();

    // Status register with random values, no pops.
    start(1'b1);
    p0 = kbd_pops;
    for (int i = 0; i < 3; i++) begin
      kbd_stat_i = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      #1;
      exp_q.push_back(kbd_stat_i);
      read_bytes(1, 0, "stat");
    end
    check("stat_nopop", kbd_pops, p0);
    stop();

    // Unmapped register.
    write_addr(8'h42);
    stop();
    start(1'b1);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_bytes(2, 0, "nodev");
    stop();

    // Mouse buffer.
    ms_push(8'h08); ms_push(8'h01); ms_push(8'hFF);
    write_addr(8'h21);
    stop();
    start(1'b1);
    p0 = ms_pops;
`ifdef SMC_MOUSE_EN
    exp_q.push_back(8'h08); exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
    read_bytes(3, 2, "ms");
    check("ms_pops", ms_pops, p0 + 3);
`else
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_bytes(2, 0, "ms_off");
    check("ms_off_pops", ms_pops, p0);
`endif
    stop();

    // Reset arriving together with a deq cancels the pop.
    kbd_push(8'h33);
    write_addr(8'h07);
    stop();
    start(1'b1);
    p0 = kbd_pops;
    txbyte_deq_i = 1'b1;
    @(negedge clk6x);
    resetn = 1'b0;
    step();
    txbyte_deq_i = 1'b0;
    check("rstmid_rd", {31'd0, kbd_code_rd_o}, 32'd0);
    check("rstmid_reg", {24'd0, reg_o}, 32'h00);
    devsel_i = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check("rstmid_nopop", kbd_pops, p0);
    start(1'b1);
    exp_q.push_back(8'hFF);
    read_bytes(1, 0, "rstmid_read");
    stop();

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
